sha256_round_ctrl: RTL

Sequencing controller for the SHA-256 compression datapath. It accepts a start request per 512-bit message block and optionally initialises the hash registers to the IV. It then loads the working variables a..h and steps the round engine through 64 rounds, stalling on message-word availability during rounds 0..15. It finishes by issuing the H += a..h update and a one-cycle done pulse. It sits between the block-level host interface and the message-schedule/compression datapath, and owns the round counter and K-ROM addressing.

---
 rtl/sha256_round_ctrl.sv | 110 +++++++++++
 1 files changed

// File: rtl/sha256_round_ctrl.sv
// SHA-256 compression sequencer: walks IDLE -> INIT -> LOAD -> 64 x ROUND -> UPDATE -> DONE
// and owns the round counter / K-ROM address. Rounds below LOAD_WORDS wait for a message word.
module sha256_round_ctrl #(
    parameter int NUM_ROUNDS = 64,
    parameter int LOAD_WORDS = 16,
    parameter int CNT_W      = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             first_block,
    input  logic             msg_valid,
    output logic             msg_ready,
    output logic             round_en,
    output logic [CNT_W-1:0] round_idx,
    output logic [CNT_W-1:0] k_addr,
    output logic             w_sel,
    output logic             init_hash,
    output logic             load_vars,
    output logic             update_hash,
    output logic             busy,
    output logic             done
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] INIT   = 3'd1;
    localparam logic [2:0] LOAD   = 3'd2;
    localparam logic [2:0] ROUND  = 3'd3;
    localparam logic [2:0] UPDATE = 3'd4;
    localparam logic [2:0] DONE   = 3'd5;

    // One extra bit so LOAD_WORDS == 2**CNT_W still compares correctly.
    localparam logic [CNT_W:0]   LOAD_LIM   = (CNT_W+1)'(LOAD_WORDS);
    localparam logic [CNT_W-1:0] LAST_ROUND = CNT_W'(NUM_ROUNDS - 1);

    generate
        if ((2 ** CNT_W) < NUM_ROUNDS) begin : g_bad_cnt_w
            $error("CNT_W too narrow for NUM_ROUNDS");
        end
    endgenerate

    logic [2:0]       state, state_nxt;
    logic [CNT_W-1:0] round_q;
    logic             fb_q;
    logic             in_load;
    logic             last_round;

    assign in_load    = ({1'b0, round_q} < LOAD_LIM);
    assign last_round = (round_q == LAST_ROUND);

    always_comb begin
        state_nxt   = state;
        msg_ready   = 1'b0;
        w_sel       = 1'b0;
        round_en    = 1'b0;
        init_hash   = 1'b0;
        load_vars   = 1'b0;
        update_hash = 1'b0;
        done        = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = INIT;
            end
            INIT: begin
                init_hash = fb_q;
                state_nxt = LOAD;
            end
            LOAD: begin
                load_vars = 1'b1;
                state_nxt = ROUND;
            end
            ROUND: begin
                msg_ready = in_load;
                w_sel     = ~in_load;
                round_en  = ~in_load | msg_valid;
                if (round_en && last_round) state_nxt = UPDATE;
            end
            UPDATE: begin
                update_hash = 1'b1;
                state_nxt   = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy      = (state != IDLE);
    assign round_idx = round_q;
    assign k_addr    = round_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            round_q <= '0;
            fb_q    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && start) fb_q <= first_block;
            if (state == LOAD) begin
                round_q <= '0;
            end else if (round_en) begin
                round_q <= last_round ? '0 : round_q + CNT_W'(1);
            end
        end
    end

endmodule
